// File: rtl/pezaris_pkg.sv
// pezaris_pkg: shared types and sizing for the row-serial Pezaris multiplier
package pezaris_pkg;
  localparam int W_DEF = 7;
  localparam int ROW_W = $clog2(W_DEF);
  typedef enum logic [1:0] {IDLE, ACCUM, MERGE, DONE} state_e;
endpackage

// File: rtl/pezaris_serial_mult_if.sv
// pezaris_serial_mult_if: operand and product handshakes of the serial multiplier
//   in_valid/in_ready/in_a/in_b    operand pair, master -> slave
//   out_valid/out_ready/out_p      signed 2W-bit product, slave -> master
interface pezaris_serial_mult_if
  import pezaris_pkg::*;
#(
  parameter int W = W_DEF
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  modport master (output in_valid, in_a, in_b, out_ready, input in_ready, out_valid, out_p);
  modport slave (input in_valid, in_a, in_b, out_ready, output in_ready, out_valid, out_p);
endinterface

// File: rtl/pezaris_cs_row.sv
// pezaris_cs_row: one combinational carry-save row of the Pezaris array
//   a_i/b_i       multiplicand and the multiplier bit of this row
//   row_i         row index; the last row carries the subtracted sign row
//   s_i/c_i       incoming sum/carry vectors
//   s_o/c_o/lsb_o next sum/carry vectors and the retiring product bit
module pezaris_cs_row
  import pezaris_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int RW = ROW_W
) (
  input  logic [W-1:0]  a_i,
  input  logic          b_i,
  input  logic [RW-1:0] row_i,
  input  logic [W-1:0]  s_i,
  input  logic [W-1:0]  c_i,
  output logic [W-1:0]  s_o,
  output logic [W-1:0]  c_o,
  output logic          lsb_o
);
  logic [W-1:0] neg;
  logic [W-1:0] x;
  logic [W-1:0] sum;
  // Negative-weight terms enter as ~pp; the -1 each leaves behind is a fixed
  // constant folded into the merge. The sign row negates every bit but a[W-1].
  assign neg   = (row_i == RW'(W - 1)) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
  assign x     = (a_i & {W{b_i}}) ^ neg;
  assign sum   = x ^ s_i ^ c_i;
  assign c_o   = (x & s_i) | (x & c_i) | (s_i & c_i);
  assign s_o   = {1'b0, sum[W-1:1]};
  assign lsb_o = sum[0];
endmodule

// File: rtl/pezaris_serial_mult.sv
// pezaris_serial_mult: row-serial two's-complement W x W multiplier, one carry-save row per clock
//   clk/rst  clock and synchronous active-high reset
//   bus      slave side of pezaris_serial_mult_if (operand and product handshakes)
module pezaris_serial_mult
  import pezaris_pkg::*;
#(
  parameter int W = W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  pezaris_serial_mult_if.slave bus
);
  localparam int RW = $clog2(W);
  state_e         state_q, state_d;
  logic [W-1:0]   a_q, b_q, s_q, c_q, lo_q;
  logic [W-1:0]   s_d, c_d, hi_d;
  logic [RW-1:0]  row_q;
  logic [2*W-1:0] p_q;
  logic           lsb_d;
  pezaris_cs_row #(.W(W), .RW(RW)) u_row (
    .a_i(a_q), .b_i(b_q[row_q]), .row_i(row_q), .s_i(s_q), .c_i(c_q),
    .s_o(s_d), .c_o(c_d), .lsb_o(lsb_d)
  );
  // Sign-term correction: +2^W and +2^(2W-1), i.e. +1 and +2^(W-1) in the high half.
  assign hi_d = s_q + c_q + W'(1) + (W'(1) << (W - 1));
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = bus.in_valid ? ACCUM : IDLE;
      ACCUM: state_d = (row_q == RW'(W - 1)) ? MERGE : ACCUM;
      MERGE: state_d = DONE;
      DONE:  state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready  = state_q == IDLE;
    bus.out_valid = state_q == DONE;
  end
  assign bus.out_p = p_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      lo_q  <= '0;
      row_q <= '0;
      p_q   <= '0;
    end else if (state_q == IDLE && bus.in_valid) begin
      a_q   <= bus.in_a;
      b_q   <= bus.in_b;
      s_q   <= '0;
      c_q   <= '0;
      lo_q  <= '0;
      row_q <= '0;
    end else if (state_q == ACCUM) begin
      s_q   <= s_d;
      c_q   <= c_d;
      lo_q  <= {lsb_d, lo_q[W-1:1]};
      row_q <= row_q + 1'b1;
    end else if (state_q == MERGE) begin
      p_q <= {hi_d, lo_q};
    end
  end
endmodule

// File: doc/pezaris_serial_mult.md
# pezaris_serial_mult

Row-serial two's-complement multiplier: accepts one W×W operand pair over a valid/ready handshake and evaluates one Pezaris carry-save row per clock. It accumulates sum and carry vectors, merges them in a final carry-propagate step, and presents the 2W-bit signed product over a second valid/ready handshake. It is the area-reduced sequential sibling of the fully combinational array: the same row arithmetic, reused W times instead of instantiated W times.

## Interface
- W, 7, operand width in bits (W ≥ 3); product width is 2W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept an operand pair (high only in IDLE)
- in_a  in  W  multiplicand, signed two's complement
- in_b  in  W  multiplier, signed two's complement
- out_valid  out  1  product available
- out_ready  in  1  consumer accepts the product
- out_p  out  2W  signed product in_a × in_b

## Operation
- States: IDLE, ACCUM, MERGE, DONE.
- IDLE: in_ready=1. When in_valid is high at an edge: latch in_a/in_b, clear the sum/carry vectors, set row=0, go to ACCUM.
- ACCUM: each edge applies row `row`: partial product a & {W{b[row]}}, with Pezaris sign handling.
  - The a[W-1] bit carries negative weight.
  - Row W-1 (the sign bit of b) is subtracted.
  - Negated-input cells carry the sign terms, so no sign extension of the vectors is needed.
  - Update sum/carry, then row++.
  - After row W-1 is applied, go to MERGE.
- MERGE: one edge. Carry-propagate add of the final sum/carry vectors plus the shifted-out low bits. The result is registered into out_p; go to DONE.
- DONE: out_valid=1. out_p is held stable. Go to IDLE on the edge where out_ready=1.
- Result must equal the exact signed product for all 2^(2W) input pairs. No overflow is possible in 2W bits.
- in_valid outside IDLE is ignored, and the operands are not sampled.
- in_a/in_b may change freely after the accept edge.
- Reset in any state forces IDLE and discards any in-flight operation; no out_valid pulse follows.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_p=0, row=0, sum/carry vectors=0.
- Accept at edge k:
  - ACCUM occupies edges k+1…k+W.
  - MERGE occurs at edge k+W+1.
  - out_valid is high from edge k+W+1 onward. Latency is W+1 cycles (8 for W=7).
- Handshakes complete only on an edge with valid & ready both high.
- out_valid & !out_ready: out_valid and out_p are held unchanged indefinitely.
- The DONE→IDLE edge and the next accept cannot coincide, because in_ready=0 in DONE. Minimum initiation interval is W+3 cycles (10 for W=7).
- in_ready and out_valid are direct state decodes, with no combinational path from in_valid/out_ready.
- rst and out_ready high at the same edge: rst wins and out_valid drops.

## Structure
- Shared package pezaris_pkg:
  - state enum (IDLE, ACCUM, MERGE, DONE)
  - default W
  - localparam for row counter width ($clog2(W))
- Sub-module pezaris_cs_row:
  - purely combinational W-bit row of full adders.
  - Type 0 cells on the positive-weight bits; cells with the third input negated on the sign terms.
  - Row-index input selects the subtract behaviour for row W-1.
  - Outputs next sum/carry plus the retiring LSB.
- Top level holds the FSM, operand/vector registers, row counter and merge adder.

## Test plan
- 3 × 5 with out_ready=1 → out_valid rises 8 cycles after accept, out_p=0x000F, in_ready returns 1 cycle after output handshake.
- −64 × −64 (0x40, 0x40) → out_p=0x1000. −64 × 63 (0x40, 0x3F) → out_p=0x3040 (−4032).
- 63 × 63 → 0x0F81. −1 × −1 → 0x0001. 0 × −64 → 0x0000.
- Hold out_ready=0 for 5 cycles after out_valid. Toggle in_valid and change in_a/in_b meanwhile → out_p stable, in_ready=0, no new accept. Product delivered when out_ready=1.
- Assert rst for one edge during ACCUM (row 3) → next cycle in_ready=1, out_valid=0, out_p=0. A following 2 × −3 yields 0x3FFA.
- Exhaustive 16384 pairs, random out_ready stalls, in_valid held continuously → every product matches the reference model; accepts spaced ≥10 cycles.
